// File: rtl/jt89_wr_arb.sv
// Two-requester write arbiter for the jt89 PSG write port.
// Requesters A (68k) and B (Z80) share one 8-bit port. Accepted bytes queue in a
// small FIFO and are replayed to the PSG as single-cycle active-low strobes. The
// strobes are spaced by a programmable number of clk_en ticks. A requester that
// sends a tone latch holds the port until its data byte arrives, or until a
// timeout expires.
module jt89_wr_arb #(
  parameter int unsigned AW      = 2,
  parameter int unsigned GAP     = 32,
  parameter int unsigned LOCK_TO = 1023
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_en,
  input  logic          a_wr,
  input  logic [7:0]    a_din,
  output logic          a_ready,
  input  logic          b_wr,
  input  logic [7:0]    b_din,
  output logic          b_ready,
  output logic          psg_wr_n,
  output logic [7:0]    psg_din,
  output logic [AW:0]   level,
  output logic          busy
);

  localparam int unsigned Depth     = 1 << AW;
  localparam logic [AW:0] FullLevel = (AW+1)'(Depth);
  localparam logic [8:0]  GapTicks  = 9'(GAP);
  localparam logic [9:0]  LockLast  = 10'(LOCK_TO - 1);

  typedef enum logic [1:0] {LockNone, LockA, LockB} lock_e;
  typedef enum logic [1:0] {StIdle, StStrobe, StHold} pacer_e;

  // FIFO storage and pointers
  logic [7:0]    mem_q [Depth];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q, level_d;
  logic          full, empty;

  // Arbitration state; last_grant_q: 0 = A, 1 = B
  lock_e         lock_q, lock_d;
  logic          last_grant_q, last_grant_d;
  logic [9:0]    to_cnt_q, to_cnt_d;

  // Pacer state
  pacer_e        st_q, st_d;
  logic [7:0]    gap_cnt_q, gap_cnt_d;
  logic [8:0]    gap_sum;
  logic          wr_n_q, wr_n_d;
  logic [7:0]    din_q, din_d;

  logic          acc_a, acc_b, push, pop;
  logic [7:0]    push_data;
  logic          push_is_tone;

  assign full  = (level_q == FullLevel);
  assign empty = (level_q == '0);

  // Ready generation: lock owner has the port alone, otherwise round-robin on ties
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    case (lock_q)
      LockA: a_ready = !full;
      LockB: b_ready = !full;
      default: begin
        a_ready = !full && (!b_wr || last_grant_q);
        b_ready = !full && (!a_wr || !last_grant_q);
      end
    endcase
  end

  assign acc_a     = a_wr && a_ready;
  assign acc_b     = b_wr && b_ready;
  assign push      = acc_a || acc_b;
  assign push_data = acc_a ? a_din : b_din;
  // Tone latch: latch byte, frequency (not volume) register, not the noise channel
  assign push_is_tone = push_data[7] && !push_data[4] && (push_data[6:5] != 2'b11);

  // Next-state for grant history, pair lock and lock idle timeout
  always_comb begin
    lock_d       = lock_q;
    last_grant_d = last_grant_q;
    to_cnt_d     = to_cnt_q;
    if (push) begin
      last_grant_d = acc_b;
    end
    case (lock_q)
      LockA, LockB: begin
        // Only the owner can be accepted while locked, so push implies owner
        if (push) begin
          to_cnt_d = '0;
          if (!push_is_tone) begin
            lock_d = LockNone;
          end
        end else if (to_cnt_q == LockLast) begin
          lock_d   = LockNone;
          to_cnt_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + 10'd1;
        end
      end
      default: begin
        to_cnt_d = '0;
        if (push && push_is_tone) begin
          lock_d = acc_a ? LockA : LockB;
        end
      end
    endcase
  end

  assign gap_sum = {1'b0, gap_cnt_q} + {8'd0, clk_en};

  // Pacer next-state: launch from IDLE on a PSG tick, chain from HOLD once the gap elapses
  always_comb begin
    st_d      = st_q;
    gap_cnt_d = gap_cnt_q;
    wr_n_d    = 1'b1;
    din_d     = din_q;
    pop       = 1'b0;
    case (st_q)
      StIdle: begin
        if (!empty && clk_en) begin
          pop    = 1'b1;
          din_d  = mem_q[rd_ptr_q];
          wr_n_d = 1'b0;
          st_d   = StStrobe;
        end
      end
      StStrobe: begin
        // The strobe cycle's own tick counts toward the spacing
        gap_cnt_d = {7'd0, clk_en};
        st_d      = StHold;
      end
      StHold: begin
        if (gap_sum >= GapTicks) begin
          gap_cnt_d = '0;
          if (!empty) begin
            pop    = 1'b1;
            din_d  = mem_q[rd_ptr_q];
            wr_n_d = 1'b0;
            st_d   = StStrobe;
          end else begin
            st_d = StIdle;
          end
        end else begin
          gap_cnt_d = gap_sum[7:0];
        end
      end
      default: begin
        st_d      = StIdle;
        gap_cnt_d = '0;
      end
    endcase
  end

  // FIFO occupancy next-state
  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      lock_q       <= LockNone;
      last_grant_q <= 1'b1;
      to_cnt_q     <= '0;
      st_q         <= StIdle;
      gap_cnt_q    <= '0;
      wr_n_q       <= 1'b1;
      din_q        <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      level_q      <= level_d;
      lock_q       <= lock_d;
      last_grant_q <= last_grant_d;
      to_cnt_q     <= to_cnt_d;
      st_q         <= st_d;
      gap_cnt_q    <= gap_cnt_d;
      wr_n_q       <= wr_n_d;
      din_q        <= din_d;
    end
  end

  // FIFO data array; contents are don't-care once pointers reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign psg_wr_n = wr_n_q;
  assign psg_din  = din_q;
  assign level    = level_q;
  assign busy     = !empty || (st_q != StIdle);

endmodule
